// File: rtl/player_motion.sv
// Sprite motion controller: frame-ticked keyboard walking with screen-edge room wrap
// and a fixed-length room transition during which input is ignored.
module player_motion #(
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 624,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 464,
    parameter int START_X     = 312,
    parameter int START_Y     = 232,
    parameter int STEP        = 2,
    parameter int ANIM_DIV    = 8,
    parameter int NUM_ANIM    = 2,
    parameter int XFER_FRAMES = 32
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_vs,
    input  logic [7:0] keycode,
    output logic [9:0] PosX,
    output logic [9:0] PosY,
    output logic [1:0] Facing,
    output logic       Moving,
    output logic [3:0] AnimFrame,
    output logic       RoomChange,
    output logic [1:0] RoomDir
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    localparam logic signed [10:0] X_MIN_S = 11'(X_MIN);
    localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
    localparam logic signed [10:0] Y_MIN_S = 11'(Y_MIN);
    localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);
    localparam logic signed [10:0] STEP_S  = 11'(STEP);

    // Returns {valid, direction} using the Facing encoding.
    function automatic logic [2:0] decode_key(input logic [7:0] code);
        case (code)
            8'h1A:   decode_key = 3'b100;
            8'h16:   decode_key = 3'b101;
            8'h04:   decode_key = 3'b110;
            8'h07:   decode_key = 3'b111;
            default: decode_key = 3'b000;
        endcase
    endfunction

    state_t      state_r, state_nxt_s;
    logic        vs_r;
    logic [15:0] div_r, div_nxt_s;
    logic [15:0] xfer_cnt_r, xfer_cnt_nxt_s;
    logic [9:0]  pos_x_nxt_s, pos_y_nxt_s;
    logic [1:0]  facing_nxt_s, room_dir_nxt_s;
    logic        moving_nxt_s, room_change_nxt_s;
    logic [3:0]  anim_nxt_s;
    logic        tick_s;
    logic [2:0]  key_s;
    logic signed [10:0] cand_x_s, cand_y_s;
    logic        out_of_bounds_s;

    // Frame tick, key decode and candidate position with bound test.
    always_comb begin
        tick_s   = frame_vs & ~vs_r;
        key_s    = decode_key(keycode);
        cand_x_s = $signed({1'b0, PosX});
        cand_y_s = $signed({1'b0, PosY});
        case (key_s[1:0])
            2'b00:   cand_y_s = $signed({1'b0, PosY}) - STEP_S;
            2'b01:   cand_y_s = $signed({1'b0, PosY}) + STEP_S;
            2'b10:   cand_x_s = $signed({1'b0, PosX}) - STEP_S;
            2'b11:   cand_x_s = $signed({1'b0, PosX}) + STEP_S;
            default: cand_x_s = $signed({1'b0, PosX});
        endcase
        if (key_s[1]) begin
            out_of_bounds_s = (cand_x_s < X_MIN_S) || (cand_x_s > X_MAX_S);
        end else begin
            out_of_bounds_s = (cand_y_s < Y_MIN_S) || (cand_y_s > Y_MAX_S);
        end
    end

    // Next-state and next-output logic; everything except the RoomChange pulse holds between ticks.
    always_comb begin
        state_nxt_s       = state_r;
        div_nxt_s         = div_r;
        xfer_cnt_nxt_s    = xfer_cnt_r;
        pos_x_nxt_s       = PosX;
        pos_y_nxt_s       = PosY;
        facing_nxt_s      = Facing;
        room_dir_nxt_s    = RoomDir;
        moving_nxt_s      = Moving;
        anim_nxt_s        = AnimFrame;
        room_change_nxt_s = 1'b0;
        if (tick_s) begin
            case (state_r)
                ST_IDLE, ST_WALK: begin
                    if (key_s[2]) begin
                        facing_nxt_s = key_s[1:0];
                        if (out_of_bounds_s) begin
                            state_nxt_s       = ST_XFER;
                            room_change_nxt_s = 1'b1;
                            room_dir_nxt_s    = key_s[1:0];
                            moving_nxt_s      = 1'b0;
                            anim_nxt_s        = 4'd0;
                            div_nxt_s         = 16'd0;
                            xfer_cnt_nxt_s    = 16'd0;
                            case (key_s[1:0])
                                2'b00:   pos_y_nxt_s = 10'(Y_MAX);
                                2'b01:   pos_y_nxt_s = 10'(Y_MIN);
                                2'b10:   pos_x_nxt_s = 10'(X_MAX);
                                2'b11:   pos_x_nxt_s = 10'(X_MIN);
                                default: pos_x_nxt_s = PosX;
                            endcase
                        end else begin
                            state_nxt_s  = ST_WALK;
                            moving_nxt_s = 1'b1;
                            pos_x_nxt_s  = cand_x_s[9:0];
                            pos_y_nxt_s  = cand_y_s[9:0];
                            if (div_r == 16'(ANIM_DIV - 1)) begin
                                div_nxt_s = 16'd0;
                                if (AnimFrame == 4'(NUM_ANIM - 1)) begin
                                    anim_nxt_s = 4'd0;
                                end else begin
                                    anim_nxt_s = AnimFrame + 4'd1;
                                end
                            end else begin
                                div_nxt_s = div_r + 16'd1;
                            end
                        end
                    end else begin
                        state_nxt_s  = ST_IDLE;
                        moving_nxt_s = 1'b0;
                        anim_nxt_s   = 4'd0;
                        div_nxt_s    = 16'd0;
                    end
                end
                ST_XFER: begin
                    moving_nxt_s = 1'b0;
                    if (xfer_cnt_r == 16'(XFER_FRAMES - 1)) begin
                        state_nxt_s    = ST_IDLE;
                        xfer_cnt_nxt_s = 16'd0;
                    end else begin
                        xfer_cnt_nxt_s = xfer_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_nxt_s  = ST_IDLE;
                    moving_nxt_s = 1'b0;
                    anim_nxt_s   = 4'd0;
                    div_nxt_s    = 16'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State and output registers; vsync copy resets high so a high vsync at release is not a tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r    <= ST_IDLE;
            vs_r       <= 1'b1;
            div_r      <= 16'd0;
            xfer_cnt_r <= 16'd0;
            PosX       <= 10'(START_X);
            PosY       <= 10'(START_Y);
            Facing     <= 2'b01;
            Moving     <= 1'b0;
            AnimFrame  <= 4'd0;
            RoomChange <= 1'b0;
            RoomDir    <= 2'b00;
        end else begin
            state_r    <= state_nxt_s;
            vs_r       <= frame_vs;
            div_r      <= div_nxt_s;
            xfer_cnt_r <= xfer_cnt_nxt_s;
            PosX       <= pos_x_nxt_s;
            PosY       <= pos_y_nxt_s;
            Facing     <= facing_nxt_s;
            Moving     <= moving_nxt_s;
            AnimFrame  <= anim_nxt_s;
            RoomChange <= room_change_nxt_s;
            RoomDir    <= room_dir_nxt_s;
        end
    end

endmodule
